frame_counter: RTL and testbench
================================

# frame_counter

Frame sequencer for the APU. Divides `apu_clk` into quarter-frame and half-frame strobes that drive the envelope, sweep and length-counter logic of the pulse channels. It also raises the frame interrupt. It sits directly upstream of each pulse channel: `qtr_clk` and `hlf_clk` feed the channel's envelope and sweep/length clock inputs.

## Interface
- `STEP1`, default 3728: counter value of the first step point.
- `STEP2`, default 7456: second step point.
- `STEP3`, default 11185: third step point.
- `STEP4`, default 14914: fourth step point; last step in 4-step mode.
- `STEP5`, default 18640: fifth step point; last step in 5-step mode.
- `CNT_W`, default 15: sequence counter width; must hold `STEP5`.
- `apu_clk  in  1`: APU clock. This is the only clock.
- `rst_n  in  1`: reset, asynchronous and active-low.
- `frame_wr  in  1`: one-cycle write strobe for register $4017.
- `frame_data  in  8`: $4017 data. [7] is mode (0 = 4-step, 1 = 5-step); [6] is irq_inhibit; [5:0] are ignored.
- `status_rd  in  1`: one-cycle strobe for a $4015 read; clears the frame IRQ.
- `qtr_clk  out  1`: quarter-frame strobe, high for one `apu_clk` cycle.
- `hlf_clk  out  1`: half-frame strobe, high for one `apu_clk` cycle.
- `frame_irq  out  1`: frame interrupt flag, level output.

## Operation
- State:
  - `cnt[CNT_W-1:0]`
  - `mode`
  - `inhibit`
  - `irq`
  - registered `qtr_clk` and `hlf_clk`
- Reset: `cnt` = 0, `mode` = 0, `inhibit` = 0, and `qtr_clk`, `hlf_clk` and `frame_irq` are all 0.
- `cnt` increments by 1 every cycle. When `cnt` equals the last step of the current mode, the next value is 0.
  - 4-step period: `STEP4`+1 = 14915 cycles.
  - 5-step period: `STEP5`+1 = 18641 cycles.
- Step decode when `cnt` == STEPk, with outputs registered for the following cycle:
  - `STEP1`: qtr.
  - `STEP2`: qtr and hlf.
  - `STEP3`: qtr.
  - `STEP4` in 4-step mode: qtr, hlf and IRQ set.
  - `STEP4` in 5-step mode: nothing.
  - `STEP5` (5-step mode only): qtr and hlf.
  - `STEP5` in 4-step mode is unreachable.
- IRQ set: occurs only at `STEP4` in 4-step mode, and only when `inhibit` = 0. The 5-step mode never sets the IRQ.
- IRQ clear:
  - `status_rd` = 1.
  - A write with [6] = 1.
- `frame_wr` behaviour on the same edge:
  - `mode` ← [7] and `inhibit` ← [6].
  - `cnt` ← 0.
  - Any step decode in that cycle is discarded.
  - If [7] = 1, `qtr_clk` and `hlf_clk` are both high in the next cycle (immediate clock).
  - If [7] = 0, no strobe is generated.
- Simultaneous events:
  - IRQ set together with `status_rd`: set wins, and `frame_irq` stays 1.
  - `frame_wr` together with a `STEP4` decode: the write wins, so there is no IRQ set and no strobes except the immediate clock.
  - `frame_wr` with [6] = 1 together with `status_rd`: the IRQ clears.
- Mode changes take effect only through `frame_wr`, which always restarts the sequence at 0. The wrap point therefore never moves mid-sequence.
- Asserting reset mid-sequence forces the reset values immediately, including the outputs. The sequence restarts from 0 after reset is released.

## Timing
- All outputs are registered. There is no combinational path from any input to any output.
- The first edge after reset release loads `cnt` = 1 (the counter started at 0 in reset).
- `qtr_clk` is high in exactly one cycle per step point: the cycle after the one in which `cnt` == STEPk.
- Write-to-strobe latency (mode 1): 1 cycle. The strobe is high in the cycle after the `frame_wr` edge.
- Write-to-first-`STEP1` strobe: `STEP1`+1 cycles.
- `frame_irq` rises 1 cycle after `cnt` == `STEP4`. It falls 1 cycle after a `status_rd` or inhibit write.
- Consecutive strobes are never adjacent. The minimum spacing equals the difference between step parameters, which is at least 2 cycles.

## Structure
- Shared package `apu_pkg` holds:
  - the default step constants
  - the $4017 bit positions `FC_MODE_BIT` (7) and `FC_INHIBIT_BIT` (6)
- `qtr_clk`/`hlf_clk` pulse channel ports are shared with the pulse and triangle channels.
- The block is a single module with no sub-module. Step decode, counter and IRQ flag fit in one block.

## Test plan
- Reset release, 4-step mode, no writes: qtr strobes at cycles 3729, 7457, 11186 and 14915. hlf strobes at 7457 and 14915. `frame_irq` rises at 14915. The next qtr strobe is at 14915+3729.
- Write 0x80 (5-step mode): qtr and hlf strobe 1 cycle later. After that, qtr strobes at offsets 3729, 7457, 11186 and 18641, with no strobe at offset 14915. `frame_irq` stays 0 over two full periods.
- Write 0x40, run 30000 cycles: normal strobes occur and `frame_irq` stays 0. Then write 0x00 with the IRQ previously set: `frame_irq` is not cleared by the mode write alone.
- Let `frame_irq` set, then pulse `status_rd`: `frame_irq` is 0 on the next cycle. Pulse `status_rd` at `cnt` == `STEP4`: `frame_irq` is 1 afterwards.
- `frame_wr` of 0x00 at `cnt` == `STEP2`: no strobe follows. The next qtr strobe is `STEP1`+1 cycles after the write.
- Assert `rst_n` low at `cnt` == 5000 in 5-step mode: all outputs are 0 immediately. After release, the mode is 4-step and the first qtr strobe is at cycle 3729.

Source files
------------

// File: rtl/apu_pkg.sv
// Shared APU constants: frame sequencer step points and $4017 bit positions.
// Latency: n/a (constants only).
// Backpressure: n/a (constants only).
package apu_pkg;

    // Default frame sequencer step points, in apu_clk cycles from sequence start
    localparam int FC_STEP1 = 3728;
    localparam int FC_STEP2 = 7456;
    localparam int FC_STEP3 = 11185;
    localparam int FC_STEP4 = 14914;
    localparam int FC_STEP5 = 18640;
    localparam int FC_CNT_W = 15;

    // $4017 register bit positions
    localparam int FC_MODE_BIT    = 7;
    localparam int FC_INHIBIT_BIT = 6;

endpackage

// File: rtl/frame_counter.sv
// APU frame sequencer: quarter/half-frame strobes and the frame interrupt flag.
// Latency: all outputs registered; strobes appear the cycle after cnt hits a step point.
// Backpressure: none; free-running, writes and status reads are single-cycle strobes.
//
// Ports:
//   apu_clk, rst_n       clock, async active-low reset
//   frame_wr, frame_data $4017 write strobe and data ([7] mode, [6] irq_inhibit)
//   status_rd            $4015 read strobe, clears the frame IRQ
//   qtr_clk, hlf_clk     one-cycle quarter/half frame strobes
//   frame_irq            frame interrupt flag (level)
module frame_counter
    import apu_pkg::*;
#(
    parameter int STEP1 = FC_STEP1,
    parameter int STEP2 = FC_STEP2,
    parameter int STEP3 = FC_STEP3,
    parameter int STEP4 = FC_STEP4,
    parameter int STEP5 = FC_STEP5,
    parameter int CNT_W = FC_CNT_W
) (
    input  logic       apu_clk,
    input  logic       rst_n,
    input  logic       frame_wr,
    input  logic [7:0] frame_data,
    input  logic       status_rd,
    output logic       qtr_clk,
    output logic       hlf_clk,
    output logic       frame_irq
);

    localparam logic [CNT_W-1:0] S1 = CNT_W'(STEP1);
    localparam logic [CNT_W-1:0] S2 = CNT_W'(STEP2);
    localparam logic [CNT_W-1:0] S3 = CNT_W'(STEP3);
    localparam logic [CNT_W-1:0] S4 = CNT_W'(STEP4);
    localparam logic [CNT_W-1:0] S5 = CNT_W'(STEP5);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             mode;
    logic             inhibit;
    logic             step_qtr;
    logic             step_hlf;
    logic             step_irq;

    // Bits [5:0] of $4017 have no function in this block
    logic unused_data;
    assign unused_data = ^frame_data[5:0];

    // Step decode and wrap. The wrap point only depends on mode, and mode only
    // changes on a write that also restarts the count, so it never moves mid-sequence.
    always_comb begin
        step_qtr = 1'b0;
        step_hlf = 1'b0;
        step_irq = 1'b0;
        cnt_nxt  = cnt + 1'b1;

        if (cnt == S1 || cnt == S3) begin
            step_qtr = 1'b1;
        end
        if (cnt == S2) begin
            step_qtr = 1'b1;
            step_hlf = 1'b1;
        end
        if (cnt == S4 && !mode) begin
            step_qtr = 1'b1;
            step_hlf = 1'b1;
            step_irq = 1'b1;
        end
        if (cnt == S5 && mode) begin
            step_qtr = 1'b1;
            step_hlf = 1'b1;
        end

        if ((mode && cnt == S5) || (!mode && cnt == S4)) begin
            cnt_nxt = '0;
        end
    end

    always_ff @(posedge apu_clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt       <= '0;
            mode      <= 1'b0;
            inhibit   <= 1'b0;
            qtr_clk   <= 1'b0;
            hlf_clk   <= 1'b0;
            frame_irq <= 1'b0;
        end else if (frame_wr) begin
            // A write restarts the sequence and overrides any step decode this
            // cycle; 5-step mode clocks the units immediately.
            cnt     <= '0;
            mode    <= frame_data[FC_MODE_BIT];
            inhibit <= frame_data[FC_INHIBIT_BIT];
            qtr_clk <= frame_data[FC_MODE_BIT];
            hlf_clk <= frame_data[FC_MODE_BIT];
            if (frame_data[FC_INHIBIT_BIT] || status_rd) begin
                frame_irq <= 1'b0;
            end
        end else begin
            cnt     <= cnt_nxt;
            qtr_clk <= step_qtr;
            hlf_clk <= step_hlf;
            // Setting beats a coincident status read clear
            if (step_irq && !inhibit) begin
                frame_irq <= 1'b1;
            end else if (status_rd) begin
                frame_irq <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_frame_counter.sv
// Scoreboard bench for frame_counter with shortened step points so several
// full sequences and a randomized phase fit in a few thousand cycles.
// Expected outputs come from a model of elapsed cycles since sequence start.
module tb_frame_counter;

    localparam int S1 = 10;
    localparam int S2 = 20;
    localparam int S3 = 31;
    localparam int S4 = 41;
    localparam int S5 = 52;
    localparam int CW = 6;

    logic       apu_clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       frame_wr = 1'b0;
    logic [7:0] frame_data = 8'h00;
    logic       status_rd = 1'b0;
    logic       qtr_clk;
    logic       hlf_clk;
    logic       frame_irq;

    frame_counter #(
        .STEP1(S1), .STEP2(S2), .STEP3(S3), .STEP4(S4), .STEP5(S5), .CNT_W(CW)
    ) dut (
        .apu_clk   (apu_clk),
        .rst_n     (rst_n),
        .frame_wr  (frame_wr),
        .frame_data(frame_data),
        .status_rd (status_rd),
        .qtr_clk   (qtr_clk),
        .hlf_clk   (hlf_clk),
        .frame_irq (frame_irq)
    );

    always #5 apu_clk = ~apu_clk;

    typedef struct packed {
        logic q;
        logic h;
        logic irq;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail = 0;

    // Reference model: elapsed edges since the sequence (re)started, plus flags
    int m_e = 0;
    bit m_mode = 1'b0;
    bit m_inh = 1'b0;
    bit m_irq = 1'b0;

    // Position within the sequence as seen by the edge about to happen
    function automatic int model_cnt();
        return m_e % (m_mode ? (S5 + 1) : (S4 + 1));
    endfunction

    task automatic model_edge(input bit wr, input logic [7:0] d, input bit rd);
        exp_t x;
        int   c;
        bit   set;
        x = '0;
        if (wr) begin
            m_mode = d[7];
            m_inh  = d[6];
            m_e    = 0;
            x.q    = d[7];
            x.h    = d[7];
            if (d[6] || rd) m_irq = 1'b0;
        end else begin
            c   = model_cnt();
            m_e = m_e + 1;
            if (c == S1 || c == S2 || c == S3) x.q = 1'b1;
            if (c == S2) x.h = 1'b1;
            set = 1'b0;
            if (!m_mode && c == S4) begin
                x.q = 1'b1;
                x.h = 1'b1;
                set = !m_inh;
            end
            if (m_mode && c == S5) begin
                x.q = 1'b1;
                x.h = 1'b1;
            end
            if (set) m_irq = 1'b1;
            else if (rd) m_irq = 1'b0;
        end
        x.irq = m_irq;
        exp_q.push_back(x);
    endtask

    // Called at posedge+1: drive inputs, take the edge, record expectation
    task automatic cycle(input bit wr, input logic [7:0] d, input bit rd);
        frame_wr   = wr;
        frame_data = d;
        status_rd  = rd;
        @(posedge apu_clk);
        model_edge(wr, d, rd);
        #1;
        frame_wr  = 1'b0;
        status_rd = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) cycle(1'b0, 8'h00, 1'b0);
    endtask

    task automatic run_to(input int target);
        for (int k = 0; k < 200 && model_cnt() != target; k++) cycle(1'b0, 8'h00, 1'b0);
    endtask

    // Reset is asserted away from the clock with nothing pending, so the
    // single zero expectation checks the outputs before the next clock edge.
    task automatic do_reset();
        exp_t z;
        z = '0;
        exp_q.push_back(z);
        rst_n = 1'b0;
        repeat (3) @(posedge apu_clk);
        #1;
        rst_n  = 1'b1;
        m_e    = 0;
        m_mode = 1'b0;
        m_inh  = 1'b0;
        m_irq  = 1'b0;
    endtask

    // Monitor: compare DUT outputs against the oldest expectation
    initial begin
        exp_t e;
        exp_t got;
        forever begin
            @(negedge apu_clk or negedge rst_n);
            #1;
            if (exp_q.size() > 0) begin
                e   = exp_q.pop_front();
                got = {qtr_clk, hlf_clk, frame_irq};
                n_checks++;
                if (got !== e) begin
                    n_fail++;
                    $display("FAIL outputs @%0t: q/h/irq got %b required %b", $time, got, e);
                end
            end
        end
    end

    initial begin
        #2;
        do_reset();

        // 4-step mode from reset: strobes, IRQ rise, continue into next period
        idle(2 * (S4 + 1) + S1 + 5);

        // Status read clears a set IRQ
        cycle(1'b0, 8'h00, 1'b1);
        idle(5);

        // Status read coincident with the IRQ set: set wins
        run_to(S4);
        cycle(1'b0, 8'h00, 1'b1);
        idle(5);

        // 5-step mode: immediate clock, no STEP4 strobe, no IRQ
        cycle(1'b1, 8'h80, 1'b0);
        idle(2 * (S5 + 1) + 5);

        // Inhibited 4-step mode: IRQ never sets
        cycle(1'b1, 8'h40, 1'b0);
        idle(3 * (S4 + 1));

        // Let IRQ set, then a plain mode write must not clear it
        cycle(1'b1, 8'h00, 1'b0);
        idle(S4 + 4);
        cycle(1'b1, 8'h00, 1'b0);
        idle(5);

        // Write 0x00 exactly at STEP2: strobe discarded, sequence restarts
        run_to(S2);
        cycle(1'b1, 8'h00, 1'b0);
        idle(S1 + 4);

        // Write coincident with STEP4 in 4-step mode: no strobes, no IRQ set
        cycle(1'b1, 8'h40, 1'b1);
        cycle(1'b1, 8'h00, 1'b0);
        run_to(S4);
        cycle(1'b1, 8'h00, 1'b0);
        idle(5);

        // Inhibit write together with a status read while IRQ is set
        idle(S4 + 2);
        cycle(1'b1, 8'h40, 1'b1);
        idle(5);

        // Reset mid-sequence in 5-step mode, then 4-step run from reset
        cycle(1'b1, 8'h80, 1'b0);
        idle(30);
        @(negedge apu_clk);
        #2;
        do_reset();
        idle(S4 + S1 + 5);

        // Randomized traffic
        for (int k = 0; k < 3000; k++) begin
            cycle(($urandom_range(0, 99) == 0), 8'($urandom), ($urandom_range(0, 29) == 0));
        end
        idle(3);

        @(negedge apu_clk);
        #3;
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
